// File: rtl/apb_slave_ctrl.sv
// Registered APB completer front-end: turns one APB transfer into a single-cycle
// backend read/write strobe, waits for ack and returns a registered response.
module apb_slave_ctrl #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 32,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'('h400),
  parameter int                TIMEOUT     = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  tim_psel,
  input  logic                  tim_penable,
  input  logic                  tim_pwrite,
  input  logic [ADDR_W-1:0]     tim_paddr,
  input  logic [DATA_W-1:0]     tim_pwdata,
  input  logic [DATA_W/8-1:0]   tim_pstrb,
  output logic [DATA_W-1:0]     tim_prdata,
  output logic                  tim_pready,
  output logic                  tim_pslverr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  ack,
  input  logic                  error
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int ALIGN_W = $clog2(STRB_W);
  localparam int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [TO_W-1:0] TO_MAX  = '1;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          wait_cnt_reg, wait_cnt_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic                req_first_reg, req_first_next;
  logic                pwrite_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   pstrb_reg;
  logic [DATA_W-1:0]   prdata_reg, prdata_next;
  logic                pready_reg, pready_next;
  logic                pslverr_reg, pslverr_next;
  logic                capture;
  logic                local_err;

  // APB penable plays no role: any selected cycle in IDLE is taken as setup.
  logic unused_penable;
  assign unused_penable = tim_penable;

  assign local_err = (addr_reg >= ADDR_LIMIT) || (|addr_reg[ALIGN_W-1:0]);

  // Strobes decode straight from registered state, so they are clean one-cycle pulses.
  assign wr_en = (state_reg == S_REQ) && req_first_reg && !local_err && pwrite_reg;
  assign rd_en = (state_reg == S_REQ) && req_first_reg && !local_err && !pwrite_reg;

  assign addr        = addr_reg;
  assign wdata       = wdata_reg;
  assign pstrb       = pstrb_reg;
  assign tim_prdata  = prdata_reg;
  assign tim_pready  = pready_reg;
  assign tim_pslverr = pslverr_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= S_IDLE;
      wait_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      req_first_reg <= 1'b0;
      pwrite_reg    <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      pstrb_reg     <= '0;
      prdata_reg    <= '0;
      pready_reg    <= 1'b0;
      pslverr_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      req_first_reg <= req_first_next;
      prdata_reg    <= prdata_next;
      pready_reg    <= pready_next;
      pslverr_reg   <= pslverr_next;
      if (capture) begin
        pwrite_reg <= tim_pwrite;
        addr_reg   <= tim_paddr;
        wdata_reg  <= tim_pwdata;
        pstrb_reg  <= tim_pwrite ? tim_pstrb : '0;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    req_first_next = 1'b0;
    capture        = 1'b0;
    prdata_next    = '0;
    pready_next    = 1'b0;
    pslverr_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (tim_psel) begin
          capture       = 1'b1;
          wait_cnt_next = WAIT_INIT;
          if (WAIT_INIT != 4'd0) begin
            state_next = S_WAIT;
          end else begin
            state_next     = S_REQ;
            req_first_next = 1'b1;
            to_cnt_next    = '0;
          end
        end
      end

      S_WAIT: begin
        if (wait_cnt_reg != 4'd0) begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
        if (!tim_psel) begin
          state_next = S_IDLE;
        end else if (wait_cnt_reg <= 4'd1) begin
          state_next     = S_REQ;
          req_first_next = 1'b1;
          to_cnt_next    = '0;
        end
      end

      S_REQ: begin
        if (!tim_psel) begin
          state_next = S_IDLE;
        end else if (local_err) begin
          state_next   = S_RESP;
          pready_next  = 1'b1;
          pslverr_next = 1'b1;
        end else if (ack) begin
          state_next   = S_RESP;
          pready_next  = 1'b1;
          pslverr_next = error;
          prdata_next  = (!pwrite_reg && !error) ? rdata : '0;
        end else if ((TIMEOUT > 0) && (to_cnt_reg == TO_LAST)) begin
          state_next   = S_RESP;
          pready_next  = 1'b1;
          pslverr_next = 1'b1;
        end else if (to_cnt_reg != TO_MAX) begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      S_RESP: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed bench: one zero-wait-state instance and one three-wait-state instance,
// checked cycle by cycle against hand-derived APB timing.
module tb_apb_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel0 = 1'b0, psel3 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb_in = '0;
  logic [31:0] rdata = '0;
  logic        ack0 = 1'b0, ack3 = 1'b0, error = 1'b0;

  logic [31:0] prdata0, prdata3, wdata0, wdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic        wr_en0, wr_en3, rd_en0, rd_en3;
  logic [11:0] addr0, addr3;
  logic [3:0]  pstrb0, pstrb3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  apb_slave_ctrl #(.WAIT_STATES(0)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .tim_psel(psel0), .tim_penable(penable), .tim_pwrite(pwrite),
    .tim_paddr(paddr), .tim_pwdata(pwdata), .tim_pstrb(pstrb_in),
    .tim_prdata(prdata0), .tim_pready(pready0), .tim_pslverr(pslverr0),
    .wr_en(wr_en0), .rd_en(rd_en0), .addr(addr0), .wdata(wdata0), .pstrb(pstrb0),
    .rdata(rdata), .ack(ack0), .error(error)
  );

  apb_slave_ctrl #(.WAIT_STATES(3)) dut3 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .tim_psel(psel3), .tim_penable(penable), .tim_pwrite(pwrite),
    .tim_paddr(paddr), .tim_pwdata(pwdata), .tim_pstrb(pstrb_in),
    .tim_prdata(prdata3), .tim_pready(pready3), .tim_pslverr(pslverr3),
    .wr_en(wr_en3), .rd_en(rd_en3), .addr(addr3), .wdata(wdata3), .pstrb(pstrb3),
    .rdata(rdata), .ack(ack3), .error(error)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    pwrite   = wr;
    paddr    = a;
    pwdata   = d;
    pstrb_in = s;
    penable  = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_val("rst_pready", 32'(pready0), 32'd0);
    check_val("rst_strobes", 32'({wr_en0, rd_en0, wr_en3, rd_en3}), 32'd0);
    check_val("rst_prdata", prdata0, 32'd0);
    rst_n = 1'b1;
    step();

    // Write, zero wait states, ack in strobe cycle
    setup(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    psel0 = 1'b1;
    step();
    check_val("wr_t1_wr_en", 32'(wr_en0), 32'd1);
    check_val("wr_t1_rd_en", 32'(rd_en0), 32'd0);
    check_val("wr_t1_addr", 32'(addr0), 32'h010);
    check_val("wr_t1_wdata", wdata0, 32'hDEADBEEF);
    check_val("wr_t1_pstrb", 32'(pstrb0), 32'hF);
    check_val("wr_t1_pready", 32'(pready0), 32'd0);
    penable = 1'b1;
    ack0 = 1'b1;
    step();
    check_val("wr_t2_pready", 32'(pready0), 32'd1);
    check_val("wr_t2_pslverr", 32'(pslverr0), 32'd0);
    check_val("wr_t2_wr_en", 32'(wr_en0), 32'd0);
    psel0 = 1'b0; penable = 1'b0; ack0 = 1'b0;
    step();
    check_val("wr_t3_pready", 32'(pready0), 32'd0);

    // Read, three wait states, ack two cycles after the strobe
    setup(1'b0, 12'h004, 32'h0, 4'hF);
    psel3 = 1'b1;
    step();
    check_val("rd3_t1_rd_en", 32'(rd_en3), 32'd0);
    penable = 1'b1;
    step();
    step();
    check_val("rd3_t3_rd_en", 32'(rd_en3), 32'd0);
    step();
    check_val("rd3_t4_rd_en", 32'(rd_en3), 32'd1);
    check_val("rd3_t4_pstrb", 32'(pstrb3), 32'd0);
    check_val("rd3_t4_addr", 32'(addr3), 32'h004);
    step();
    check_val("rd3_t5_rd_en", 32'(rd_en3), 32'd0);
    step();
    ack3 = 1'b1;
    rdata = 32'h12345678;
    step();
    check_val("rd3_t7_pready", 32'(pready3), 32'd1);
    check_val("rd3_t7_pslverr", 32'(pslverr3), 32'd0);
    check_val("rd3_t7_prdata", prdata3, 32'h12345678);
    psel3 = 1'b0; penable = 1'b0; ack3 = 1'b0;
    step();
    check_val("rd3_t8_pready", 32'(pready3), 32'd0);
    check_val("rd3_t8_prdata", prdata3, 32'd0);

    // Local errors: out of range write, misaligned read
    setup(1'b1, 12'h400, 32'h11111111, 4'hF);
    psel0 = 1'b1;
    step();
    check_val("lim_t1_strobe", 32'({wr_en0, rd_en0}), 32'd0);
    penable = 1'b1;
    step();
    check_val("lim_t2_resp", 32'({pready0, pslverr0}), 32'b11);
    check_val("lim_t2_prdata", prdata0, 32'd0);
    psel0 = 1'b0; penable = 1'b0;
    step();
    setup(1'b0, 12'h002, 32'h0, 4'h0);
    psel0 = 1'b1;
    step();
    check_val("mis_t1_strobe", 32'({wr_en0, rd_en0}), 32'd0);
    penable = 1'b1;
    ack0 = 1'b1;
    rdata = 32'hCAFEF00D;
    step();
    check_val("mis_t2_resp", 32'({pready0, pslverr0}), 32'b11);
    check_val("mis_t2_prdata", prdata0, 32'd0);
    psel0 = 1'b0; penable = 1'b0; ack0 = 1'b0;
    step();

    // Timeout: ack held low, response exactly 8 cycles after the strobe
    setup(1'b1, 12'h020, 32'h55AA55AA, 4'h3);
    psel0 = 1'b1;
    step();
    check_val("to_t1_wr_en", 32'(wr_en0), 32'd1);
    penable = 1'b1;
    for (int i = 2; i <= 8; i++) step();
    check_val("to_t8_pready", 32'(pready0), 32'd0);
    step();
    check_val("to_t9_resp", 32'({pready0, pslverr0}), 32'b11);
    check_val("to_t9_prdata", prdata0, 32'd0);
    psel0 = 1'b0; penable = 1'b0;
    step();
    ack0 = 1'b1;
    step();
    check_val("late_ack_pready", 32'(pready0), 32'd0);
    check_val("late_ack_strobe", 32'({wr_en0, rd_en0}), 32'd0);
    ack0 = 1'b0;
    setup(1'b0, 12'h008, 32'h0, 4'h0);
    psel0 = 1'b1;
    step();
    check_val("post_to_rd_en", 32'(rd_en0), 32'd1);
    penable = 1'b1;
    ack0 = 1'b1;
    rdata = 32'hA5A5C3C3;
    step();
    check_val("post_to_resp", 32'({pready0, pslverr0}), 32'b10);
    check_val("post_to_prdata", prdata0, 32'hA5A5C3C3);
    psel0 = 1'b0; penable = 1'b0; ack0 = 1'b0;
    step();

    // Backend error on a read
    setup(1'b0, 12'h00C, 32'h0, 4'h0);
    psel0 = 1'b1;
    step();
    penable = 1'b1;
    ack0 = 1'b1;
    error = 1'b1;
    rdata = 32'hFFFFFFFF;
    step();
    check_val("berr_resp", 32'({pready0, pslverr0}), 32'b11);
    check_val("berr_prdata", prdata0, 32'd0);
    psel0 = 1'b0; penable = 1'b0; ack0 = 1'b0; error = 1'b0;
    step();

    // Abort in WAIT: no strobe, no pready afterwards
    setup(1'b1, 12'h030, 32'h77777777, 4'hF);
    psel3 = 1'b1;
    step();
    psel3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("abort_quiet", 32'({wr_en3, rd_en3, pready3}), 32'd0);
    end

    // Asynchronous reset while waiting for ack
    setup(1'b0, 12'h014, 32'h0, 4'h0);
    psel0 = 1'b1;
    step();
    check_val("arst_rd_en", 32'(rd_en0), 32'd1);
    penable = 1'b1;
    step();
    check_val("arst_addr_before", 32'(addr0), 32'h014);
    rst_n = 1'b0;
    #1;
    check_val("arst_addr_after", 32'(addr0), 32'd0);
    check_val("arst_outputs", 32'({wr_en0, rd_en0, pready0, pslverr0}), 32'd0);
    psel0 = 1'b0; penable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    setup(1'b0, 12'h018, 32'h0, 4'h0);
    psel0 = 1'b1;
    step();
    check_val("fresh_rd_en", 32'(rd_en0), 32'd1);
    penable = 1'b1;
    ack0 = 1'b1;
    rdata = 32'h0BADF00D;
    step();
    check_val("fresh_resp", 32'({pready0, pslverr0}), 32'b10);
    check_val("fresh_prdata", prdata0, 32'h0BADF00D);
    psel0 = 1'b0; penable = 1'b0; ack0 = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_ctrl.md
Name: apb_slave_ctrl

Overview:
- Parametrised, registered APB3/APB4 completer front-end for timer-class register blocks.
- Decodes tim_* APB transfers into single-cycle backend read/write strobes with a backend ready/ack handshake.
- Supports programmable wait states, local address/alignment error detection, backend timeout, and transfer abort.
- Sits between the APB interconnect and the block's register file.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, data width; 32 or 64 only; strobe width STRB_W = DATA_W/8.
- WAIT_STATES, 0, extra idle cycles inserted before the backend strobe (0..15).
- ADDR_LIMIT, 12'h400, first invalid byte address; any address >= ADDR_LIMIT is a local error.
- TIMEOUT, 8, maximum number of cycles to wait for ack after a strobe; 0 disables the timeout.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset
- tim_psel  in  1  APB select
- tim_penable  in  1  APB enable
- tim_pwrite  in  1  1 = write
- tim_paddr  in  ADDR_W  byte address
- tim_pwdata  in  DATA_W  write data
- tim_pstrb  in  STRB_W  write byte strobes
- tim_prdata  out  DATA_W  read data, registered
- tim_pready  out  1  transfer complete, registered
- tim_pslverr  out  1  error response, registered
- wr_en  out  1  backend write strobe, 1-cycle pulse
- rd_en  out  1  backend read strobe, 1-cycle pulse
- addr  out  ADDR_W  captured address
- wdata  out  DATA_W  captured write data
- pstrb  out  STRB_W  captured strobes; forced 0 on reads
- rdata  in  DATA_W  backend read data, valid with ack
- ack  in  1  backend completion
- error  in  1  backend error, sampled with ack

Interface: reset sys_rst_n, asynchronous, active-low; clock sys_clk.

Behaviour:
- Reset: state = IDLE; all outputs 0; internal counters 0.
- IDLE:
  - On tim_psel=1, capture paddr, pwdata, pstrb and pwrite.
  - Load wait_cnt = WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else go to REQ.
- WAIT: decrement wait_cnt each cycle; go to REQ when wait_cnt reaches 1.
- REQ, first cycle:
  - Local error if addr >= ADDR_LIMIT, or addr not aligned to DATA_W/8 bytes. Then no strobe is issued; set err=1 and go to RESP.
  - Otherwise assert wr_en or rd_en for exactly this cycle and clear to_cnt.
- REQ, ack handling:
  - ack may arrive in the strobe cycle or in any later cycle.
  - On ack: latch rdata (reads only) and error into err; go to RESP.
  - If TIMEOUT > 0 and to_cnt reaches TIMEOUT without ack: set err=1, set prdata=0, go to RESP.
  - Any ack arriving after the timeout is ignored.
- RESP:
  - tim_pready=1 for exactly one cycle.
  - tim_pslverr = err (never asserted without pready).
  - tim_prdata = latched data on a successful read, otherwise 0.
  - Next state IDLE; tim_prdata returns to 0.
- Abort: if tim_psel=0 in WAIT or REQ, return to IDLE.
  - pready is not asserted.
  - A strobe already issued is not retracted; the late ack is ignored.
- Back-to-back: a new transfer can be captured in the cycle after RESP (IDLE sees psel). No transfer is pipelined or overlapped.
- Latency with WAIT_STATES=0 and ack in the strobe cycle:
  - setup cycle t0 (IDLE captures);
  - t1: penable, REQ, strobe;
  - t2: pready.
  - Result: 1 APB wait state. Each extra wait state or ack delay cycle adds 1 cycle.
- Write with tim_pstrb=0 is legal: wr_en still pulses with pstrb=0.
- tim_penable is not required for capture. A protocol violation (penable=1 in IDLE) is treated as setup.
- Counter widths: wait_cnt 4 bits; to_cnt = clog2(TIMEOUT+1) bits. Counters saturate; no wrap-around.

Test Plan:
- Write, WAIT_STATES=0, addr 12'h010, data 32'hDEADBEEF, strb 4'hF, ack in the strobe cycle -> wr_en pulses at t1 with addr 12'h010 / wdata 32'hDEADBEEF / pstrb 4'hF; pready=1, pslverr=0 at t2.
- Read, WAIT_STATES=3, addr 12'h004, ack 2 cycles after the strobe with rdata 32'h12345678 -> rd_en at t4, pready at t7, prdata 32'h12345678, pstrb=0.
- Access to addr 12'h400 and to 12'h002 -> no wr_en/rd_en; pready at t2 with pslverr=1; prdata=0.
- TIMEOUT=8, ack held low -> pready with pslverr=1 exactly 8 cycles after the strobe. A late ack is ignored and the next transfer completes normally.
- Backend error=1 with ack on a read -> pslverr=1 with pready, prdata=0. Also: psel dropped in WAIT -> IDLE, no strobe, no pready.
- Assert sys_rst_n low mid-REQ -> all outputs 0 immediately (asynchronous). A fresh read after reset completes with the nominal latency.
